ahb_apb_bridge: RTL
===================

# ahb_apb_bridge

AHB-Lite slave to APB master bridge: accepts single AHB-Lite transfers and turns each into one APB setup/access sequence on a two-slave APB segment. It drives PSEL1/PSEL2 of the existing APB slaves, and it returns read data and error status to the AHB side with wait states. HCLK and PCLK are the same clock; there is no clock-domain crossing.

## Interface
- ADDR_WIDTH, 32, AHB/APB address width
- DATA_WIDTH, 32, AHB/APB data width
- SEL_BIT, 3, PADDR bit that selects the slave (0 selects slave 1, 1 selects slave 2)

- PCLK  in  1  single clock for both the AHB and APB sides
- PRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  bridge selected on AHB
- HADDR  in  ADDR_WIDTH  AHB address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase
- HREADY  in  1  AHB bus ready
- HREADYOUT  out  1  bridge ready
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  1  0 = OKAY, 1 = ERROR
- PSEL1, PSEL2  out  1  APB slave selects
- PENABLE  out  1  APB access phase
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA1, PRDATA2  in  DATA_WIDTH  slave read data
- PREADY1, PREADY2  in  1  slave ready
- PSLVERR  in  1  shared slave error

## Operation
- Accept a transfer when HSEL & HREADY & HTRANS[1] are high. On accept, register HADDR, HWRITE, and the slave select (HADDR[SEL_BIT]).
- IDLE/BUSY transfers, or an unselected bridge, get a zero-wait OKAY response. No APB activity results.
- HSIZE > 3'b010 is illegal. The bridge goes straight to ERR1 with no APB access.
- FSM states are IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: on an accepted read go to SETUP; on an accepted write go to WDATA.
  - WDATA: latch HWDATA into PWDATA, then go to SETUP.
  - SETUP: PSELx=1, PENABLE=0. Go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1. Hold while the selected PREADY is 0.
    - Selected PREADY=1 with PSLVERR=0: complete OKAY and go to IDLE. On a read, register the selected PRDATA into HRDATA.
    - Selected PREADY=1 with PSLVERR=1: go to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Can accept a new transfer, exactly as IDLE does.
- PREADY and PRDATA are muxed by the registered slave select. The unselected slave's PREADY is ignored.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the final ACCESS cycle.
- HRDATA holds its last value until the next read completes.

## Timing
- Reset (asynchronous, immediate): PSEL1=PSEL2=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0, HRESP=0, HREADYOUT=1, FSM=IDLE.
- Read, zero-wait slave, address phase in cycle N:
  - N+1 is SETUP, N+2 is ACCESS, both with HREADYOUT=0.
  - N+3 has HREADYOUT=1 and HRDATA valid.
- Write, zero-wait slave: WDATA at N+1, SETUP at N+2, ACCESS at N+3, HREADYOUT=1 at N+4.
- Each cycle of PREADY=0 in ACCESS adds one cycle. HREADYOUT stays 0 throughout.
- A new transfer presented in the cycle HREADYOUT=1 (completion or ERR2) is accepted. Its SETUP or WDATA follows in the next cycle with no idle gap.
- Reset asserted mid-transfer aborts it immediately. APB outputs drop in the same cycle. The aborted transfer is not completed after reset.
- PSEL1 and PSEL2 are never high together.

## Structure
- Shared package amba_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/HRESP_ERROR
  - the bridge state enum
- These are reused by the existing APB master/slave and future AHB blocks.
- Sub-module apb_addr_decode: combinational; takes ADDR and SEL_BIT and returns a one-hot select[1:0]. It is shared with any future APB decoder.
- Everything else, FSM and datapath registers, lives in ahb_apb_bridge.

## Test plan
- Write: HADDR=12, HWDATA=30 → PSEL2 high for 2 cycles with PADDR=12, PWDATA=30, PWRITE=1. HREADYOUT low for 3 cycles. HRESP=0.
- Read back: HADDR=12 read → PSEL2 SETUP then ACCESS. HRDATA=30 at N+3. PSEL1 stays 0.
- Back-to-back: write HADDR=3, HWDATA=2, then a read of 3 issued in the completion cycle → the second SETUP starts in the next cycle. HRDATA=2. Only PSEL1 is used.
- Wait states: PREADY1 held low for 3 ACCESS cycles → PADDR/PWDATA stable throughout. HREADYOUT low for 3 extra cycles.
- Errors:
  - PSLVERR=1 with PREADY → HRESP=1 for 2 cycles: HREADYOUT=0, then HREADYOUT=1.
  - HSIZE=3'b011 → same 2-cycle error with no PSEL pulse.
- Reset during ACCESS → all APB outputs 0 immediately and HREADYOUT=1. After PRESETn rises, a fresh read of 3 completes normally.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AMBA encodings and the AHB-to-APB bridge state type.
// Used by the bridge and by neighbouring APB/AHB blocks.
package amba_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Largest supported transfer size (word).
  localparam logic [2:0] HSIZE_MAX = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB slave decode: one address bit picks one of two slaves,
// returned as a one-hot select.
module apb_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BIT    = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            select
);

  // Only one bit takes part in the decode; the rest are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sel
      if (gi == 1) begin : g_hi
        assign select[gi] = addr[SEL_BIT];
      end else begin : g_lo
        assign select[gi] = ~addr[SEL_BIT];
      end
    end
  endgenerate

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to two-slave APB master bridge; one APB setup/access per
// accepted AHB transfer, wait states and error response on the AHB side.
module ahb_apb_bridge
  import amba_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BIT    = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic                  PSLVERR
);

  bridge_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  write_reg;
  logic [1:0]            sel_reg;
  logic [1:0]            sel_dec;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [DATA_WIDTH-1:0] hrdata_reg;
  logic                  apb_sel;
  logic                  accept;
  logic                  can_accept;
  logic                  pready_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_BIT    (SEL_BIT)
  ) u_decode (
    .addr   (HADDR),
    .select (sel_dec)
  );

  assign accept     = HSEL && HREADY && is_active_trans(HTRANS);
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);

  // The unselected slave's handshake and data never influence the transfer.
  assign pready_sel = (sel_reg[0] & PREADY1) | (sel_reg[1] & PREADY2);
  assign prdata_sel = sel_reg[1] ? PRDATA2 : PRDATA1;

  always_comb begin
    state_next = state_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    apb_sel    = 1'b0;
    PENABLE    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        if (state_reg == ST_ERR2) HRESP = HRESP_ERROR;
        state_next = ST_IDLE;
        if (accept) begin
          if (HSIZE > HSIZE_MAX) state_next = ST_ERR1;
          else if (HWRITE)       state_next = ST_WDATA;
          else                   state_next = ST_SETUP;
        end
      end
      ST_WDATA: begin
        HREADYOUT  = 1'b0;
        state_next = ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT  = 1'b0;
        apb_sel    = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        apb_sel   = 1'b1;
        PENABLE   = 1'b1;
        if (pready_sel) state_next = PSLVERR ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      sel_reg    <= '0;
      pwdata_reg <= '0;
      hrdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (can_accept && accept) begin
        addr_reg  <= HADDR;
        write_reg <= HWRITE;
        sel_reg   <= sel_dec;
      end
      if (state_reg == ST_WDATA) pwdata_reg <= HWDATA;
      if ((state_reg == ST_ACCESS) && pready_sel && !PSLVERR && !write_reg)
        hrdata_reg <= prdata_sel;
    end
  end

  assign PSEL1  = apb_sel & sel_reg[0];
  assign PSEL2  = apb_sel & sel_reg[1];
  assign PADDR  = addr_reg;
  assign PWRITE = write_reg;
  assign PWDATA = pwdata_reg;
  assign HRDATA = hrdata_reg;

endmodule
